// File: rtl/alarm_controller.sv
// Alarm stage for the clock counter: stores the alarm time, detects the daily
// match on the 1 Hz tick and runs the ring/snooze/stop state machine.
module alarm_controller #(
  parameter int RING_SECS       = 60,
  parameter int SNOOZE_SECS     = 300,
  parameter int ALARM_HOUR_INIT = 7,
  parameter int ALARM_MIN_INIT  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [4:0] hour,
  input  logic [5:0] mins,
  input  logic [5:0] secs,
  input  logic       alarm_on,
  input  logic       set_alarm,
  input  logic       ahour_inc,
  input  logic       amin_inc,
  input  logic       stop,
  input  logic       snooze,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic [3:0] ahour1,
  output logic [1:0] ahour2,
  output logic [3:0] amin1,
  output logic [2:0] amin2,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);

  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_SECS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RING = 2'd1;
  localparam logic [1:0] S_SNZ  = 2'd2;

  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);
  localparam logic [4:0]    HOUR_INIT = 5'(ALARM_HOUR_INIT);
  localparam logic [5:0]    MIN_INIT  = 6'(ALARM_MIN_INIT);

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic          beep_q, beep_d;
  logic [4:0]    ahour_q, ahour_d;
  logic [5:0]    amin_q, amin_d;
  logic          match;

  // Minute wraps without carrying into the hour.
  always_comb begin
    ahour_d = ahour_q;
    amin_d  = amin_q;
    if (set_alarm) begin
      if (ahour_inc) ahour_d = (ahour_q == 5'd23) ? 5'd0 : ahour_q + 5'd1;
      if (amin_inc)  amin_d  = (amin_q == 6'd59)  ? 6'd0 : amin_q + 6'd1;
    end
  end

  assign match = en & (hour == ahour_q) & (mins == amin_q) & (secs == 6'd0);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    beep_d     = beep_q;
    case (state_q)
      S_IDLE: begin
        if (match & alarm_on & ~set_alarm) begin
          state_d    = S_RING;
          ring_cnt_d = '0;
          beep_d     = 1'b1;
        end
      end
      S_RING: begin
        // Pulses are checked before the tick so they win over count/toggle.
        if (stop | ~alarm_on) begin
          state_d = S_IDLE;
          beep_d  = 1'b0;
        end else if (snooze) begin
          state_d   = S_SNZ;
          snz_cnt_d = '0;
        end else if (en) begin
          if (ring_cnt_q == RING_LAST) begin
            state_d = S_IDLE;
            beep_d  = 1'b0;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
            beep_d     = ~beep_q;
          end
        end
      end
      S_SNZ: begin
        if (stop | ~alarm_on) begin
          state_d = S_IDLE;
          beep_d  = 1'b0;
        end else if (en) begin
          if (snz_cnt_q == SNZ_LAST) begin
            state_d    = S_RING;
            ring_cnt_d = '0;
            beep_d     = 1'b1;
          end else begin
            snz_cnt_d = snz_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        beep_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      beep_q     <= 1'b0;
      ahour_q    <= HOUR_INIT;
      amin_q     <= MIN_INIT;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      beep_q     <= beep_d;
      ahour_q    <= ahour_d;
      amin_q     <= amin_d;
    end
  end

  // Decoded straight from the registers so reset drops the buzzer immediately.
  assign ringing    = (state_q == S_RING);
  assign snoozing   = (state_q == S_SNZ);
  assign buzzer     = ringing & beep_q;
  assign alarm_hour = ahour_q;
  assign alarm_min  = amin_q;
  assign ahour1     = 4'(ahour_q % 5'd10);
  assign ahour2     = 2'(ahour_q / 5'd10);
  assign amin1      = 4'(amin_q % 6'd10);
  assign amin2      = 3'(amin_q / 6'd10);

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: table-driven vectors checked through an expected
// queue, plus set-mode loops and an asynchronous reset mid-ring.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [4:0] hour;
  logic [5:0] mins, secs;
  logic       alarm_on, set_alarm, ahour_inc, amin_inc, stop, snooze;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [3:0] ahour1, amin1;
  logic [1:0] ahour2;
  logic [2:0] amin2;
  logic       ringing, snoozing, buzzer;

  int n_chk  = 0;
  int n_fail = 0;

  alarm_controller #(
    .RING_SECS(4), .SNOOZE_SECS(3), .ALARM_HOUR_INIT(7), .ALARM_MIN_INIT(0)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .hour(hour), .mins(mins), .secs(secs),
    .alarm_on(alarm_on), .set_alarm(set_alarm), .ahour_inc(ahour_inc),
    .amin_inc(amin_inc), .stop(stop), .snooze(snooze),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .ahour1(ahour1),
    .ahour2(ahour2), .amin1(amin1), .amin2(amin2),
    .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en;
    logic [4:0] h;
    logic [5:0] m, s;
    logic       on, set, ahi, ami, stp, snz;
    int         eah, eam;
    logic       er, es, eb;
  } vec_t;

  typedef struct {
    string       name;
    logic [26:0] exp;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic vec_t mk(string name, logic e, int h, int m, int s,
                              logic on, logic set, logic ahi, logic ami,
                              logic stp, logic snz, int eah, int eam,
                              logic er, logic es, logic eb);
    vec_t v;
    v.name = name; v.en = e; v.h = 5'(h); v.m = 6'(m); v.s = 6'(s);
    v.on = on; v.set = set; v.ahi = ahi; v.ami = ami; v.stp = stp; v.snz = snz;
    v.eah = eah; v.eam = eam; v.er = er; v.es = es; v.eb = eb;
    return v;
  endfunction

  // Expected display digits are derived from the expected alarm time.
  function automatic logic [26:0] pack_exp(int ah, int am, logic r, logic s, logic b);
    return {5'(ah), 6'(am), 2'(ah / 10), 4'(ah % 10), 3'(am / 10), 4'(am % 10), r, s, b};
  endfunction

  function automatic logic [26:0] obs();
    return {alarm_hour, alarm_min, ahour2, ahour1, amin2, amin1, ringing, snoozing, buzzer};
  endfunction

  task automatic check(input string name, input logic [26:0] got, input logic [26:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ah=%0d am=%0d dig=%0d%0d:%0d%0d r/s/b=%b%b%b, want ah=%0d am=%0d dig=%0d%0d:%0d%0d r/s/b=%b%b%b",
               name, got[26:22], got[21:16], got[15:14], got[13:10], got[9:7], got[6:3],
               got[2], got[1], got[0], exp[26:22], exp[21:16], exp[15:14], exp[13:10],
               exp[9:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    en = v.en; hour = v.h; mins = v.m; secs = v.s;
    alarm_on = v.on; set_alarm = v.set; ahour_inc = v.ahi; amin_inc = v.ami;
    stop = v.stp; snooze = v.snz;
    exp_q.push_back('{v.name, pack_exp(v.eah, v.eam, v.er, v.es, v.eb)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(e.name, obs(), e.exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 0; hour = 0; mins = 0; secs = 0;
    alarm_on = 0; set_alarm = 0; ahour_inc = 0; amin_inc = 0; stop = 0; snooze = 0;
    #2;
    check("reset_state", obs(), pack_exp(7, 0, 0, 0, 0));
    #10;
    reset = 1'b0;

    // Set mode: 3 hour pulses, 61 minute pulses (minute wraps, no hour carry).
    for (int i = 0; i < 3; i++)
      apply(mk("set_hour", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 8 + i, 0, 0, 0, 0));
    for (int i = 0; i < 61; i++)
      apply(mk("set_min", 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 10, (i + 1) % 60, 0, 0, 0));
    apply(mk("pulses_no_set", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 10, 1, 0, 0, 0));
    apply(mk("both_pulses", 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 11, 2, 0, 0, 0));
    for (int i = 0; i < 13; i++)
      apply(mk("hour_wrap", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, (12 + i) % 24, 2, 0, 0, 0));
    do_reset();

    // name, en, h, m, s, on, set, ahi, ami, stp, snz, eah, eam, er, es, eb
    tbl.push_back(mk("no_ring_secs1",   1, 7, 0, 1, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk("no_ring_off",     1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk("no_ring_setmode", 1, 7, 0, 0, 1, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk("no_ring_no_en",   0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk("trigger",         1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1));
    tbl.push_back(mk("ring_hold",       0, 7, 0, 1, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1));
    tbl.push_back(mk("ring_tick1",      1, 7, 0, 1, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0));
    tbl.push_back(mk("ring_tick2_match",1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1));
    tbl.push_back(mk("ring_tick3",      1, 7, 0, 2, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0));
    tbl.push_back(mk("ring_hold2",      0, 7, 0, 2, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0));
    tbl.push_back(mk("ring_timeout",    1, 7, 0, 3, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk("idle_after_to",   0, 7, 0, 3, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk("trigger2",        1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1));
    tbl.push_back(mk("snooze",          0, 7, 0, 1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0));
    tbl.push_back(mk("snz_tick1",       1, 7, 0, 1, 1, 0, 0, 0, 0, 0, 7, 0, 0, 1, 0));
    tbl.push_back(mk("snz_ignored",     0, 7, 0, 2, 1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0));
    tbl.push_back(mk("snz_tick2",       1, 7, 0, 2, 1, 0, 0, 0, 0, 0, 7, 0, 0, 1, 0));
    tbl.push_back(mk("snz_resume",      1, 7, 0, 3, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1));
    tbl.push_back(mk("resume_tick",     1, 7, 0, 4, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0));
    tbl.push_back(mk("snooze_on_tick",  1, 7, 0, 5, 1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0));
    tbl.push_back(mk("snz_tick_b",      1, 7, 0, 6, 1, 0, 0, 0, 0, 0, 7, 0, 0, 1, 0));
    tbl.push_back(mk("stop_in_snz",     0, 7, 0, 6, 1, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk("trigger3",        1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1));
    tbl.push_back(mk("stop_and_snooze", 0, 7, 0, 1, 1, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0));
    tbl.push_back(mk("trigger4",        1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1));
    tbl.push_back(mk("r4_tick1",        1, 7, 0, 1, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0));
    tbl.push_back(mk("r4_tick2",        1, 7, 0, 2, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1));
    tbl.push_back(mk("r4_tick3",        1, 7, 0, 3, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0));
    tbl.push_back(mk("snooze_last_tick",1, 7, 0, 4, 1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0));
    tbl.push_back(mk("off_in_snz",      0, 7, 0, 4, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk("trigger5",        1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1));
    tbl.push_back(mk("off_in_ring",     0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk("trigger6",        1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1));
    tbl.push_back(mk("set_while_ring",  0, 7, 0, 1, 1, 1, 0, 1, 0, 0, 7, 1, 1, 0, 1));
    tbl.push_back(mk("ring_after_set",  1, 7, 0, 1, 1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0));
    tbl.push_back(mk("stop_ring",       0, 7, 0, 2, 1, 0, 0, 0, 1, 0, 7, 1, 0, 0, 0));
    tbl.push_back(mk("old_time_no_ring",1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0));
    tbl.push_back(mk("trigger_0701",    1, 7, 1, 0, 1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 1));
    foreach (tbl[i]) apply(tbl[i]);

    // Reset between edges must drop the buzzer without a clock.
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", obs(), pack_exp(7, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(mk("idle_after_reset", 0, 7, 1, 1, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm stage that sits directly downstream of the seconds/minutes/hours counter. It consumes the live `hour`/`mins`/`secs` values and the same 1 Hz `en` tick. It holds a user-settable alarm time, detects the match, and runs a ring/snooze/stop state machine that drives the buzzer. It also exports the alarm time as BCD digits for the display mux.

## Interface
- `RING_SECS`, default 60: ticks the alarm rings before it stops itself.
- `SNOOZE_SECS`, default 300: ticks spent in snooze before ringing resumes.
- `ALARM_HOUR_INIT`, default 7: alarm hour loaded on reset (0–23).
- `ALARM_MIN_INIT`, default 0: alarm minute loaded on reset (0–59).

- `clk` in 1: system clock, all state on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state to reset values.
- `en` in 1: 1 Hz tick, one `clk` wide, the same signal that drives the seconds counter.
- `hour` in 5: current hour, 0–23.
- `mins` in 6: current minute, 0–59.
- `secs` in 6: current second, 0–59.
- `alarm_on` in 1: level; alarm armed.
- `set_alarm` in 1: level; alarm-set mode.
- `ahour_inc` in 1: single-cycle pulse; increment alarm hour.
- `amin_inc` in 1: single-cycle pulse; increment alarm minute.
- `stop` in 1: single-cycle pulse; dismiss the alarm.
- `snooze` in 1: single-cycle pulse; snooze the alarm.
- `alarm_hour` out 5: stored alarm hour.
- `alarm_min` out 6: stored alarm minute.
- `ahour1` out 4: alarm hour units digit, `alarm_hour % 10`.
- `ahour2` out 2: alarm hour tens digit, `alarm_hour / 10`.
- `amin1` out 4: alarm minute units digit, `alarm_min % 10`.
- `amin2` out 3: alarm minute tens digit, `alarm_min / 10`.
- `ringing` out 1: high in state RINGING.
- `snoozing` out 1: high in state SNOOZE.
- `buzzer` out 1: `ringing & beep`, the audible output.

## Operation
- **Alarm time registers**
  - `amin_inc` applies only while `set_alarm` = 1. It takes `alarm_min` 59 → 0, with no carry into the hour.
  - `ahour_inc` applies only while `set_alarm` = 1. It takes `alarm_hour` 23 → 0.
  - Both pulses in the same cycle: both fields increment.
  - Pulses while `set_alarm` = 0 are ignored.
  - The BCD digit outputs are combinational from the registers.
- **Match**
  - `match = en & (hour == alarm_hour) & (mins == alarm_min) & (secs == 0)`.
  - `secs == 0` restricts it to one trigger per day, at the tick that leaves second 00.
- **State machine**: states IDLE, RINGING, SNOOZE; reset → IDLE.
- **IDLE**
  - Goes to RINGING on `match & alarm_on & ~set_alarm`.
  - Entering RINGING clears `ring_cnt` and sets `beep` to 1.
- **RINGING**
  - Exit priority, highest first:
    1. `stop` → IDLE.
    2. `~alarm_on` → IDLE.
    3. `snooze` → SNOOZE, with `snz_cnt` cleared.
    4. `en` with `ring_cnt == RING_SECS-1` → IDLE (auto-timeout).
  - Otherwise each `en` increments `ring_cnt` and toggles `beep`.
- **SNOOZE**
  - Exit priority, highest first:
    1. `stop` → IDLE.
    2. `~alarm_on` → IDLE.
    3. `en` with `snz_cnt == SNOOZE_SECS-1` → RINGING, with `ring_cnt` cleared and `beep` = 1.
  - Otherwise each `en` increments `snz_cnt`.
  - `snooze` is ignored in SNOOZE.
- `match` is ignored in RINGING and SNOOZE; it does not re-arm or restart the counters.
- Snooze may repeat without limit.
- Counter widths: `$clog2(RING_SECS+1)` for `ring_cnt` and `$clog2(SNOOZE_SECS+1)` for `snz_cnt`; the counters never exceed `PARAM-1`.
- Changing the alarm time during RINGING/SNOOZE is allowed and does not affect the current cycle.

## Timing
- Reset values:
  - state IDLE; `ringing`, `snoozing`, `buzzer` = 0.
  - `alarm_hour` = `ALARM_HOUR_INIT`, `alarm_min` = `ALARM_MIN_INIT`.
  - BCD outputs track those values immediately.
  - `ring_cnt`, `snz_cnt` = 0; `beep` = 0.
- `ringing`/`snoozing` are registered. They rise on the `clk` edge that samples `match`, `snooze` or the timeout, i.e. 1-cycle latency.
- `stop`/`snooze` take effect on the edge that samples them. A pulse coincident with `en` wins over the tick's count/toggle.
- Alarm-time increments are visible on the outputs one cycle after the pulse.
- `reset` mid-ring drops `buzzer` asynchronously, with no wait for `clk`.
- Ring duration is exactly `RING_SECS` ticks of `en`; snooze duration is exactly `SNOOZE_SECS` ticks.

## Test plan
- **Reset and set mode:** reset, then `set_alarm` = 1 with 3 × `ahour_inc` and 61 × `amin_inc`. Required: `alarm_hour` = 10, `alarm_min` = 1; `ahour2` = 1, `ahour1` = 0, `amin2` = 0, `amin1` = 1. The same pulses with `set_alarm` = 0 leave the values unchanged.
- **Trigger:** alarm 07:00, `alarm_on` = 1, drive 07:00:00 with `en`. Required: `ringing` = 1 on the next cycle and `buzzer` toggles each tick. The same with `alarm_on` = 0 gives no ring; 07:00:01 with `en` gives no ring.
- **Auto-timeout:** `RING_SECS` = 4, trigger and let ring. Required: `ringing` falls on the 4th `en` after entry, state IDLE, `buzzer` = 0.
- **Snooze cycle:** `SNOOZE_SECS` = 3, snooze while ringing. Required: `snoozing` = 1 for 3 ticks, then `ringing` = 1 with `beep` = 1. `stop` during SNOOZE → IDLE.
- **Simultaneous pulses:** `stop` and `snooze` in the same cycle while ringing → IDLE. `snooze` coincident with the final ring tick → SNOOZE.
- **Async reset mid-ring:** assert `reset` between clock edges while RINGING. Required: `buzzer`/`ringing` = 0 immediately, and the alarm time returns to the INIT values.
